// File: rtl/vec_mem_sequencer_if.sv
// Bundle of request, response and scalar-memory signals between a vector client,
// the vec_mem_sequencer and the segmented scalar data memory.
interface vec_mem_sequencer_if #(
    parameter int WIDTH = 24,
    parameter int LANES = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WIDTH-1:0]       req_addr;
    logic [LANES*WIDTH-1:0] req_wdata;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [LANES*WIDTH-1:0] resp_rdata;
    logic                   resp_err;

    logic [WIDTH-1:0]       mem_a;
    logic [WIDTH-1:0]       mem_wd;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_rd;

    // The master drives requests, takes responses and supplies the memory read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_wd, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Serialises one unit-stride vector load/store into LANES scalar memory accesses.
// Stores are range-checked as a whole against the output segment before any write.
module vec_mem_sequencer #(
    parameter int WIDTH     = 24,
    parameter int LANES     = 4,
    parameter int OUT_BASE  = 24,
    parameter int OUT_LIMIT = 10024
) (
    input  logic                clk,
    input  logic                rst_n,
    vec_mem_sequencer_if.slave  bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [LANE_W-1:0]      lane;
    logic [WIDTH-1:0]       base_q;
    logic [LANES*WIDTH-1:0] wdata_q;
    logic [LANES*WIDTH-1:0] rdata_q;
    logic                   we_q;
    logic                   err_q;

    logic                   accept;
    logic                   last_lane;
    logic                   range_bad;
    logic                   reject;
    logic [WIDTH:0]         lane_sum;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign last_lane = (lane == LANE_W'(LANES - 1));
    assign reject    = bus.req_we && range_bad;

    // The extra sum bit makes an address that wraps past 2^WIDTH-1 count as out of range.
    always_comb begin
        range_bad = 1'b0;
        lane_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = {1'b0, bus.req_addr} + (WIDTH+1)'(i);
            if ((lane_sum < (WIDTH+1)'(OUT_BASE)) || (lane_sum >= (WIDTH+1)'(OUT_LIMIT))) begin
                range_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = reject ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (last_lane) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane    <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                base_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= reject;
                lane    <= '0;
            end else if (state == ACCESS) begin
                if (!we_q) begin
                    rdata_q[int'(lane)*WIDTH +: WIDTH] <= bus.mem_rd;
                end
                lane <= last_lane ? '0 : lane + 1'b1;
            end
        end
    end

    // Memory port is purely decoded from state so mem_we drops the instant reset asserts.
    always_comb begin
        bus.mem_a  = '0;
        bus.mem_wd = '0;
        bus.mem_we = 1'b0;
        if (state == ACCESS) begin
            bus.mem_a = base_q + WIDTH'(lane);
            if (we_q) begin
                bus.mem_we = 1'b1;
                bus.mem_wd = wdata_q[int'(lane)*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed vector table, hand-written
// back-to-back and mid-access reset sequences, then random requests against a memory model.
module tb_vec_mem_sequencer;
    localparam int WIDTH     = 24;
    localparam int LANES     = 4;
    localparam int OUT_BASE  = 24;
    localparam int OUT_LIMIT = 10024;
    localparam int VW        = LANES * WIDTH;
    localparam logic [WIDTH-1:0] START_IO_ADDR = 24'd180302;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vec_mem_sequencer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus();

    vec_mem_sequencer #(
        .WIDTH(WIDTH), .LANES(LANES), .OUT_BASE(OUT_BASE), .OUT_LIMIT(OUT_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] fix_mem [0:OUT_LIMIT-1];
    logic [WIDTH-1:0] ref_mem [0:OUT_LIMIT-1];
    logic             start_io;
    int               write_count;
    int               total_checks;
    int               pass_checks;

    // Fixture memory: input segment read-only, output segment writable, startIO mapped high.
    assign bus.mem_rd = (bus.mem_a < WIDTH'(OUT_LIMIT)) ? fix_mem[bus.mem_a[13:0]] :
                        (bus.mem_a == START_IO_ADDR)    ? {{(WIDTH-1){1'b0}}, start_io} :
                                                          {WIDTH{1'b0}};

    always @(posedge clk) begin
        if (bus.mem_we) begin
            write_count = write_count + 1;
            if (bus.mem_a >= WIDTH'(OUT_BASE) && bus.mem_a < WIDTH'(OUT_LIMIT)) begin
                fix_mem[bus.mem_a[13:0]] = bus.mem_wd;
            end
        end
    end

    typedef struct {
        string            name;
        bit               we;
        logic [WIDTH-1:0] addr;
        logic [VW-1:0]    wdata;
        bit               exp_err;
        logic [VW-1:0]    exp_rdata;
        int               hold;
    } vec_t;

    vec_t vectors [14];

    function automatic logic [WIDTH-1:0] ref_read(input longint addr);
        longint a;
        a = addr % (longint'(1) << WIDTH);
        if (a < OUT_LIMIT) return ref_mem[int'(a)];
        if (a == longint'(START_IO_ADDR)) return {{(WIDTH-1){1'b0}}, start_io};
        return {WIDTH{1'b0}};
    endfunction

    function automatic bit ref_reject(input bit we, input longint addr);
        return we && ((addr < OUT_BASE) || (addr + LANES - 1 >= OUT_LIMIT));
    endfunction

    function automatic logic [VW-1:0] ref_load(input longint addr);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = ref_read(addr + i);
        return r;
    endfunction

    task automatic ref_store(input longint addr, input logic [VW-1:0] wdata);
        for (int i = 0; i < LANES; i++) ref_mem[int'(addr) + i] = wdata[i*WIDTH +: WIDTH];
    endtask

    task automatic checkOutput(input string name, input logic [VW-1:0] actual,
                               input logic [VW-1:0] expected);
        total_checks++;
        if (actual === expected) pass_checks++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input bit we, input logic [WIDTH-1:0] addr,
                                 input logic [VW-1:0] wdata);
        @(negedge clk);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        checkOutput("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // One complete request: accept, per-lane memory port checks, held response, handshake.
    task automatic runRequest(input string name, input bit we, input logic [WIDTH-1:0] addr,
                              input logic [VW-1:0] wdata, input bit exp_err,
                              input logic [VW-1:0] exp_rdata, input int hold);
        int               wc0;
        int               n;
        bit               got;
        bit               exp_we;
        logic [WIDTH-1:0] exp_a;
        wc0    = write_count;
        exp_we = we && !exp_err;
        n      = 0;
        got    = 1'b0;
        applyStimulus(we, addr, wdata);
        for (int c = 0; c < LANES + 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            if (n < LANES) begin
                exp_a = addr + WIDTH'(n);
                checkOutput({name, "/mem_a"}, bus.mem_a, exp_a);
                checkOutput({name, "/mem_we"}, bus.mem_we, exp_we);
                checkOutput({name, "/mem_wd"}, bus.mem_wd,
                            exp_we ? wdata[n*WIDTH +: WIDTH] : {WIDTH{1'b0}});
            end
            n++;
        end
        checkOutput({name, "/resp_seen"}, got, 1);
        checkOutput({name, "/access_cycles"}, n, exp_err ? 0 : LANES);
        if (got) begin
            checkOutput({name, "/resp_err"}, bus.resp_err, exp_err);
            checkOutput({name, "/resp_rdata"}, bus.resp_rdata, exp_rdata);
            checkOutput({name, "/req_ready_resp"}, bus.req_ready, 0);
            for (int h = 0; h < hold; h++) begin
                bus.req_we    = 1'b1;
                bus.req_addr  = 24'd5000;
                bus.req_wdata = {$urandom(), $urandom(), $urandom()};
                bus.req_valid = 1'b1;
                @(negedge clk);
                checkOutput({name, "/hold_valid"}, bus.resp_valid, 1);
                checkOutput({name, "/hold_rdata"}, bus.resp_rdata, exp_rdata);
                checkOutput({name, "/hold_err"}, bus.resp_err, exp_err);
                checkOutput({name, "/hold_ready"}, bus.req_ready, 0);
            end
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
            bus.req_valid  = 1'b0;
            @(negedge clk);
            checkOutput({name, "/valid_after_hs"}, bus.resp_valid, 0);
            checkOutput({name, "/ready_after_hs"}, bus.req_ready, 1);
        end
        checkOutput({name, "/write_count"}, write_count - wc0, exp_we ? LANES : 0);
        if (exp_we) ref_store(addr, wdata);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VW-1:0]    w;
        logic [WIDTH-1:0] a;
        bit               we;
        bit               got;
        int               wc0;

        vectors[0]  = '{"load0",    1'b0, 24'd0,        '0, 1'b0, {24'd13, 24'd12, 24'd11, 24'd10}, 0};
        vectors[1]  = '{"st100",    1'b1, 24'd100,      {24'hD, 24'hC, 24'hB, 24'hA}, 1'b0, '0, 1};
        vectors[2]  = '{"ld100",    1'b0, 24'd100,      '0, 1'b0, {24'hD, 24'hC, 24'hB, 24'hA}, 5};
        vectors[3]  = '{"st10021",  1'b1, 24'd10021,    {24'h9, 24'h8, 24'h7, 24'h6}, 1'b1, '0, 0};
        vectors[4]  = '{"st20",     1'b1, 24'd20,       {24'h9, 24'h8, 24'h7, 24'h6}, 1'b1, '0, 2};
        vectors[5]  = '{"st24",     1'b1, 24'd24,       {24'd4, 24'd3, 24'd2, 24'd1}, 1'b0, '0, 0};
        vectors[6]  = '{"ld22",     1'b0, 24'd22,       '0, 1'b0, {24'd2, 24'd1, 24'd33, 24'd32}, 0};
        vectors[7]  = '{"ld_io",    1'b0, 24'd180300,   '0, 1'b0, {24'd0, 24'd1, 24'd0, 24'd0}, 0};
        vectors[8]  = '{"ld_wrap",  1'b0, 24'hFFFFFE,   '0, 1'b0, {24'd11, 24'd10, 24'd0, 24'd0}, 1};
        vectors[9]  = '{"st_wrap",  1'b1, 24'hFFFFFE,   {24'h5, 24'h5, 24'h5, 24'h5}, 1'b1, '0, 0};
        vectors[10] = '{"st10020",  1'b1, 24'd10020,    {24'h44, 24'h33, 24'h22, 24'h11}, 1'b0, '0, 0};
        vectors[11] = '{"ld10020",  1'b0, 24'd10020,    '0, 1'b0, {24'h44, 24'h33, 24'h22, 24'h11}, 0};
        vectors[12] = '{"st10023",  1'b1, 24'd10023,    {24'h1, 24'h1, 24'h1, 24'h1}, 1'b1, '0, 0};
        vectors[13] = '{"ld10022",  1'b0, 24'd10022,    '0, 1'b0, {24'h0, 24'h0, 24'h44, 24'h33}, 0};

        total_checks = 0;
        pass_checks  = 0;
        write_count  = 0;
        start_io     = 1'b0;
        for (int i = 0; i < OUT_LIMIT; i++) begin
            fix_mem[i] = (i < OUT_BASE) ? WIDTH'(10 + i) : {WIDTH{1'b0}};
            ref_mem[i] = (i < OUT_BASE) ? WIDTH'(10 + i) : {WIDTH{1'b0}};
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset/req_ready", bus.req_ready, 1);
        checkOutput("reset/resp_valid", bus.resp_valid, 0);
        checkOutput("reset/resp_rdata", bus.resp_rdata, 0);
        checkOutput("reset/resp_err", bus.resp_err, 0);
        checkOutput("reset/mem_a", bus.mem_a, 0);
        checkOutput("reset/mem_wd", bus.mem_wd, 0);
        checkOutput("reset/mem_we", bus.mem_we, 0);

        start_io = 1'b1;
        for (int v = 0; v < 14; v++) begin
            runRequest(vectors[v].name, vectors[v].we, vectors[v].addr, vectors[v].wdata,
                       vectors[v].exp_err, vectors[v].exp_rdata, vectors[v].hold);
        end

        // Back-to-back: a request pending through the handshake is taken one cycle later.
        w   = {24'h3D, 24'h3C, 24'h3B, 24'h3A};
        wc0 = write_count;
        applyStimulus(1'b0, 24'd4, '0);
        got = 1'b0;
        for (int c = 0; c < LANES + 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("b2b/load_seen", got, 1);
        checkOutput("b2b/load_rdata", bus.resp_rdata, {24'd17, 24'd16, 24'd15, 24'd14});
        bus.req_we    = 1'b1;
        bus.req_addr  = 24'd300;
        bus.req_wdata = w;
        bus.req_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("b2b/ready_in_resp", bus.req_ready, 0);
            checkOutput("b2b/valid_in_resp", bus.resp_valid, 1);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("b2b/idle_after_hs", bus.req_ready, 1);
        checkOutput("b2b/valid_after_hs", bus.resp_valid, 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b/accepted", bus.req_ready, 0);
        checkOutput("b2b/mem_a_lane0", bus.mem_a, 300);
        checkOutput("b2b/mem_we_lane0", bus.mem_we, 1);
        got = 1'b0;
        for (int c = 0; c < LANES + 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("b2b/store_seen", got, 1);
        checkOutput("b2b/store_err", bus.resp_err, 0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("b2b/writes", write_count - wc0, LANES);
        ref_store(300, w);

        // Reset during lane 1 of a store: only lane 0 lands, mem_we drops without a clock.
        w   = {24'h14, 24'h13, 24'h12, 24'h11};
        wc0 = write_count;
        applyStimulus(1'b1, 24'd200, w);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst/async_mem_we", bus.mem_we, 0);
        checkOutput("rst/async_mem_a", bus.mem_a, 0);
        checkOutput("rst/async_mem_wd", bus.mem_wd, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst/req_ready", bus.req_ready, 1);
        checkOutput("rst/resp_valid", bus.resp_valid, 0);
        checkOutput("rst/resp_rdata", bus.resp_rdata, 0);
        checkOutput("rst/resp_err", bus.resp_err, 0);
        checkOutput("rst/mem_we", bus.mem_we, 0);
        checkOutput("rst/writes", write_count - wc0, 1);
        checkOutput("rst/mem200", fix_mem[200], 24'h11);
        checkOutput("rst/mem201", fix_mem[201], 24'h0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("rst/no_resp", bus.resp_valid, 0);
        end
        ref_mem[200] = 24'h11;

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       a = WIDTH'($urandom_range(0, 30));
                1:       a = WIDTH'($urandom_range(10016, 10026));
                2:       a = WIDTH'($urandom_range(OUT_BASE, 10020));
                3:       a = WIDTH'($urandom_range(180296, 180304));
                default: a = 24'hFFFFFF - WIDTH'($urandom_range(0, 5));
            endcase
            we       = 1'($urandom_range(0, 1));
            w        = {$urandom(), $urandom(), $urandom()};
            start_io = 1'($urandom_range(0, 1));
            runRequest("rand", we, a, w, ref_reject(we, a),
                       we ? {VW{1'b0}} : ref_load(a), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end
endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Vector load/store sequencer directly upstream of the segmented scalar data memory: input segment 0..23, output pixel segment 24..10023, start switch at 180302.
- Accepts one LANES-wide unit-stride vector request and serialises it into LANES scalar memory accesses on the memory's single address/write-data/write-enable port.
- For loads, reassembles the returned 24-bit words into a vector. For stores, range-checks the whole vector against the output segment before any write is issued.

Parameters:
WIDTH, 24, data and address width of the scalar memory port
LANES, 4, elements per vector (≥2)
OUT_BASE, 24, first writable address (output pixel segment)
OUT_LIMIT, 10024, first address past the writable segment

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  vector request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  WIDTH  base address (lane i at req_addr+i)
req_wdata  in  LANES*WIDTH  store data, lane i in bits [i*WIDTH +: WIDTH]
resp_valid  out  1  request finished
resp_ready  in  1  consumer takes the response
resp_rdata  out  LANES*WIDTH  load result, same lane packing as req_wdata
resp_err  out  1  store rejected (out of range)
mem_a  out  WIDTH  scalar memory address
mem_wd  out  WIDTH  scalar write data
mem_we  out  1  scalar write enable
mem_rd  in  WIDTH  scalar read data, combinational from mem_a

Behaviour:
- Reset: async on rst_n low.
  - state=IDLE; lane counter=0; latched address, data and op cleared.
  - resp_rdata=0, resp_err=0, resp_valid=0, mem_a=0, mem_wd=0, mem_we=0. mem_we must fall immediately, without waiting for clk.
  - req_ready=1 once reset is released.
- FSM IDLE / ACCESS / RESP. req_ready = (state==IDLE); no request is accepted in any other state.
- IDLE: on req_valid&&req_ready at a clk edge:
  - Latch req_we, req_addr, req_wdata; clear resp_rdata; lane=0.
  - Store with any lane address outside [OUT_BASE, OUT_LIMIT): go to RESP with resp_err=1, no write issued.
  - Otherwise: go to ACCESS with resp_err=0.
- Range check: performed on the WIDTH+1-bit sum base+i. An overflow past 2^WIDTH-1 counts as out of range.
- ACCESS, one lane per cycle:
  - mem_a = base+lane, truncated to WIDTH.
  - Store: mem_we=1, mem_wd = lane data.
  - Load: mem_we=0, mem_wd=0; mem_rd is captured into lane slot `lane` at the clk edge.
  - lane increments each cycle. On the edge where lane==LANES-1: go to RESP, lane=0.
- Load addresses are not range-checked; whatever the memory returns is captured:
  - 0 for unmapped addresses;
  - startIO zero-extended at 180302.
  Wrapped load addresses simply wrap.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable until resp_ready. On resp_valid&&resp_ready go to IDLE. resp_valid deasserts next cycle.
- Outside ACCESS: mem_we=0, mem_a=0, mem_wd=0.
- Latency, counted from the accept edge:
  - normal request: resp_valid rises LANES cycles later;
  - rejected store: resp_valid rises 1 cycle later.
  Throughput is one request per LANES+2 cycles when resp_ready is held high.
- Store responses: resp_rdata=0.
- Back-to-back: a new request is only accepted in IDLE, i.e. the cycle after the response handshake.
- Reset mid-ACCESS: remaining lanes are abandoned and no response is produced. Lanes already written stay written.

Test Plan:
- Load base=0, memory input segment holding 10,11,12,13 at 0..3 -> mem_a = 0,1,2,3 on consecutive cycles, mem_we=0. resp_valid 4 cycles after accept; resp_rdata lanes = 10,11,12,13.
- Store base=100, wdata lanes 0xA,0xB,0xC,0xD -> mem_we=1 for exactly 4 cycles at mem_a 100..103 with matching mem_wd. resp_err=0. A follow-up load of 100 returns 0xA,0xB,0xC,0xD.
- Store base=10021, lanes reaching 10024 -> mem_we never asserted. resp_valid 1 cycle after accept with resp_err=1.
- Store base=20, lane 3 at 23 -> rejected (resp_err=1, no write).
- Store base=24 -> accepted, writes at 24..27.
- Load base=180300 with startIO=1 -> lane 2 = 1; lanes 0, 1, 3 = 0.
- resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0. New req_valid is ignored until the cycle after the handshake.
- rst_n pulsed low during lane 1 of a store to 200 -> mem_we drops asynchronously and only address 200 is written. After release: req_ready=1, resp_valid=0, all outputs 0.
